// File: rtl/mem_access_pkg.sv
// Shared encodings, FSM state type and lane helpers for the MEM-stage access unit.
// Lanes are little-endian; reserved size 2'b11 behaves as a word everywhere.
package mem_access_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {
    IDLE   = 1'b0,
    RMW_WR = 1'b1
  } state_t;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return lane[0];
      default: return lane != 2'b00;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [1:0] size, input logic sgn,
                                              input logic [1:0] lane, input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(word >> {lane, 3'b000});
    h = 16'(word >> {lane[1], 4'b0000});
    case (size)
      SZ_BYTE: return {{24{sgn & b[7]}}, b};
      SZ_HALF: return {{16{sgn & h[15]}}, h};
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] lane_merge(input logic [1:0] size, input logic [1:0] lane,
                                             input logic [31:0] old, input logic [31:0] wdata);
    logic [31:0] mask;
    logic [31:0] data;
    case (size)
      SZ_BYTE: begin
        mask = 32'h0000_00FF << {lane, 3'b000};
        data = {24'b0, wdata[7:0]} << {lane, 3'b000};
      end
      SZ_HALF: begin
        mask = 32'h0000_FFFF << {lane[1], 4'b0000};
        data = {16'b0, wdata[15:0]} << {lane[1], 4'b0000};
      end
      default: begin
        mask = '1;
        data = wdata;
      end
    endcase
    return (old & ~mask) | (data & mask);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: load extract/extend and store read-modify-write merge.
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic        is_signed,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  assign load_data = load_extend(size, is_signed, lane, rdata);
  assign merged    = lane_merge(size, lane, rdata, wdata);

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage initiator toward a word-organised data memory; sub-word stores use a 2-cycle RMW.
// Optional performance counters are enabled with `define MEM_ACCESS_PERF_EN.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int WORD_IDX_W = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
`ifdef MEM_ACCESS_PERF_EN
  ,
  output logic [31:0] perf_loads,
  output logic [31:0] perf_stores,
  output logic [31:0] perf_stall_cycles
`endif
);

  state_t                state, state_nxt;
  logic [WORD_IDX_W-1:0] idx, rmw_idx, addr_idx;
  logic [31:0]           rmw_data, load_data, merged;
  logic                  take, mis, sub_word, err_now, is_load, is_wstore, is_sstore;
  logic                  unused_addr_hi;

  assign unused_addr_hi = ^req_addr[31:WORD_IDX_W+2];

  assign idx       = req_addr[WORD_IDX_W+1:2];
  assign mis       = is_misaligned(req_size, req_addr[1:0]);
  assign sub_word  = (req_size == SZ_BYTE) || (req_size == SZ_HALF);
  assign take      = (state == IDLE) && req_valid && !reset;
  assign err_now   = take && mis;
  assign is_load   = take && !mis && !req_write;
  assign is_wstore = take && !mis && req_write && !sub_word;
  assign is_sstore = take && !mis && req_write && sub_word;

  mem_lane_align u_align (
    .size      (req_size),
    .lane      (req_addr[1:0]),
    .is_signed (req_signed),
    .rdata     (mem_read_data),
    .wdata     (req_wdata),
    .load_data (load_data),
    .merged    (merged)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (is_sstore) state_nxt = RMW_WR;
      RMW_WR:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Address and data stay at zero unless a strobe is actually driven.
  always_comb begin
    req_ready      = 1'b0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    addr_idx       = '0;
    mem_write_data = '0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (is_load || is_sstore) begin
          mem_read = 1'b1;
          addr_idx = idx;
        end
        if (is_wstore) begin
          mem_write      = 1'b1;
          addr_idx       = idx;
          mem_write_data = req_wdata;
        end
      end
      RMW_WR: begin
        if (!reset) begin
          mem_write      = 1'b1;
          addr_idx       = rmw_idx;
          mem_write_data = rmw_data;
        end
      end
      default: ;
    endcase
  end

  assign mem_address = 32'(addr_idx);

  always_ff @(posedge clk) begin
    if (reset) begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      rmw_idx    <= '0;
      rmw_data   <= '0;
    end else begin
      resp_valid <= is_load || err_now;
      resp_err   <= err_now;
      if (is_load)      resp_rdata <= load_data;
      else if (err_now) resp_rdata <= '0;
      if (is_sstore) begin
        rmw_idx  <= idx;
        rmw_data <= merged;
      end
    end
  end

`ifdef MEM_ACCESS_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_loads        <= '0;
      perf_stores       <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (is_load)                perf_loads        <= perf_loads + 32'd1;
      if (is_wstore || is_sstore) perf_stores       <= perf_stores + 32'd1;
      if (state == RMW_WR)        perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural word memory on the memory port.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_read, mem_write;
  logic [31:0] mem_address, mem_write_data, mem_read_data;
`ifdef MEM_ACCESS_PERF_EN
  logic [31:0] perf_loads, perf_stores, perf_stall_cycles;
`endif

  int errors = 0;
  int checks = 0;
  int n_loads = 0, n_stores = 0, n_stalls = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.WORD_IDX_W(10)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_size       (req_size),
    .req_signed     (req_signed),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
`ifdef MEM_ACCESS_PERF_EN
    ,
    .perf_loads        (perf_loads),
    .perf_stores       (perf_stores),
    .perf_stall_cycles (perf_stall_cycles)
`endif
  );

  // Word memory: preloaded on the first edge, then written by the DUT's strobe.
  logic [31:0] mem [0:1023];
  logic        init_done = 1'b0;
  always @(posedge clk) begin
    if (!init_done) begin
      mem[0]    <= 32'h0000_0000;
      mem[2]    <= 32'h0000_0003;
      mem[3]    <= 32'h0000_0001;
      mem[4]    <= 32'h0000_8005;
      mem[5]    <= 32'h1122_3344;
      mem[7]    <= 32'h0000_0000;
      init_done <= 1'b1;
    end else if (mem_write) begin
      mem[mem_address[9:0]] <= mem_write_data;
    end
  end
  assign mem_read_data = mem[mem_address[9:0]];

  typedef struct {
    logic        wr;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        e_rd;
    logic        e_wr;
    logic [31:0] e_addr;
    logic [31:0] e_wd;
    logic        e_rv;
    logic        e_err;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [31:0] addr, input logic [31:0] wd);
    req_valid  = 1'b1;
    req_write  = wr;
    req_size   = sz;
    req_signed = sg;
    req_addr   = addr;
    req_wdata  = wd;
  endtask

  task automatic run_vec(input int i);
    @(negedge clk);
    drive(vecs[i].wr, vecs[i].sz, vecs[i].sg, vecs[i].addr, vecs[i].wd);
    #1;
    chk($sformatf("v%0d req_ready", i), 32'(req_ready), 32'd1);
    chk($sformatf("v%0d mem_read", i), 32'(mem_read), 32'(vecs[i].e_rd));
    chk($sformatf("v%0d mem_write", i), 32'(mem_write), 32'(vecs[i].e_wr));
    chk($sformatf("v%0d mem_address", i), mem_address, vecs[i].e_addr);
    chk($sformatf("v%0d mem_write_data", i), mem_write_data, vecs[i].e_wd);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    chk($sformatf("v%0d resp_valid", i), 32'(resp_valid), 32'(vecs[i].e_rv));
    chk($sformatf("v%0d resp_err", i), 32'(resp_err), 32'(vecs[i].e_err));
    chk($sformatf("v%0d resp_rdata", i), resp_rdata, vecs[i].e_rdata);
    if (vecs[i].e_wr) begin
      chk($sformatf("v%0d mem_word", i), mem[vecs[i].e_addr[9:0]], vecs[i].e_wd);
      n_stores++;
    end
    if (vecs[i].e_rv && !vecs[i].e_err) n_loads++;
  endtask

  initial begin
    //            wr    sz     sg    addr          wdata           rd    wr    addr   wd             rv    err   rdata
    vecs[0]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0008, 32'h0,         1'b1, 1'b0, 32'd2, 32'h0,         1'b1, 1'b0, 32'h0000_0003};
    vecs[1]  = '{1'b0, 2'b00, 1'b1, 32'h0000_0010, 32'h0,         1'b1, 1'b0, 32'd4, 32'h0,         1'b1, 1'b0, 32'h0000_0005};
    vecs[2]  = '{1'b0, 2'b01, 1'b1, 32'h0000_0010, 32'h0,         1'b1, 1'b0, 32'd4, 32'h0,         1'b1, 1'b0, 32'hFFFF_8005};
    vecs[3]  = '{1'b0, 2'b01, 1'b0, 32'h0000_0010, 32'h0,         1'b1, 1'b0, 32'd4, 32'h0,         1'b1, 1'b0, 32'h0000_8005};
    vecs[4]  = '{1'b0, 2'b00, 1'b1, 32'h0000_0011, 32'h0,         1'b1, 1'b0, 32'd4, 32'h0,         1'b1, 1'b0, 32'hFFFF_FF80};
    vecs[5]  = '{1'b0, 2'b00, 1'b0, 32'h0000_0011, 32'h0,         1'b1, 1'b0, 32'd4, 32'h0,         1'b1, 1'b0, 32'h0000_0080};
    vecs[6]  = '{1'b0, 2'b01, 1'b1, 32'h0000_0012, 32'h0,         1'b1, 1'b0, 32'd4, 32'h0,         1'b1, 1'b0, 32'h0000_0000};
    vecs[7]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0006, 32'h0,         1'b0, 1'b0, 32'd0, 32'h0,         1'b1, 1'b1, 32'h0000_0000};
    vecs[8]  = '{1'b1, 2'b01, 1'b0, 32'h0000_000B, 32'h1234,      1'b0, 1'b0, 32'd0, 32'h0,         1'b1, 1'b1, 32'h0000_0000};
    vecs[9]  = '{1'b1, 2'b10, 1'b0, 32'h0000_001C, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'd7, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0000_0000};
    vecs[10] = '{1'b0, 2'b11, 1'b0, 32'h0000_001C, 32'h0,         1'b1, 1'b0, 32'd7, 32'h0,         1'b1, 1'b0, 32'hDEAD_BEEF};
    vecs[11] = '{1'b1, 2'b10, 1'b0, 32'h0000_001A, 32'h5A5A_5A5A, 1'b0, 1'b0, 32'd0, 32'h0,         1'b1, 1'b1, 32'h0000_0000};
    vecs[12] = '{1'b0, 2'b11, 1'b1, 32'h0000_001E, 32'h0,         1'b0, 1'b0, 32'd0, 32'h0,         1'b1, 1'b1, 32'h0000_0000};
    vecs[13] = '{1'b0, 2'b00, 1'b0, 32'h0000_001F, 32'h0,         1'b1, 1'b0, 32'd7, 32'h0,         1'b1, 1'b0, 32'h0000_00DE};
    vecs[14] = '{1'b0, 2'b10, 1'b0, 32'h0000_1008, 32'h0,         1'b1, 1'b0, 32'd2, 32'h0,         1'b1, 1'b0, 32'h0000_0003};

    reset = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);

    // Strobes must stay low while reset is held, even with a request present.
    drive(1'b1, 2'b10, 1'b0, 32'h0000_0008, 32'hFFFF_FFFF);
    #1;
    chk("reset mem_read", 32'(mem_read), 32'd0);
    chk("reset mem_write", 32'(mem_write), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    req_valid = 1'b0;
    #1;
    chk("reset resp_valid", 32'(resp_valid), 32'd0);
    chk("reset resp_err", 32'(resp_err), 32'd0);
    chk("reset resp_rdata", resp_rdata, 32'd0);
    chk("reset req_ready", 32'(req_ready), 32'd1);
    chk("idle mem_address", mem_address, 32'd0);
    chk("reset mem_word2", mem[2], 32'h0000_0003);

    for (int i = 0; i < 15; i++) run_vec(i);

    // Byte store RMW followed directly by a load of the same word.
    @(negedge clk);
    drive(1'b1, 2'b00, 1'b0, 32'h0000_000D, 32'h0000_00AB);
    #1;
    chk("rmw rd req_ready", 32'(req_ready), 32'd1);
    chk("rmw rd mem_read", 32'(mem_read), 32'd1);
    chk("rmw rd mem_write", 32'(mem_write), 32'd0);
    chk("rmw rd mem_address", mem_address, 32'd3);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    chk("rmw wr req_ready", 32'(req_ready), 32'd0);
    chk("rmw wr mem_read", 32'(mem_read), 32'd0);
    chk("rmw wr mem_write", 32'(mem_write), 32'd1);
    chk("rmw wr mem_address", mem_address, 32'd3);
    chk("rmw wr mem_write_data", mem_write_data, 32'h0000_AB01);
    chk("rmw wr resp_valid", 32'(resp_valid), 32'd0);
    n_stores++; n_stalls++;
    @(negedge clk);
    drive(1'b0, 2'b10, 1'b0, 32'h0000_000C, 32'h0);
    #1;
    chk("rmw done req_ready", 32'(req_ready), 32'd1);
    chk("rmw done mem_word3", mem[3], 32'h0000_AB01);
    chk("b2b load mem_read", 32'(mem_read), 32'd1);
    chk("b2b load mem_write", 32'(mem_write), 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    n_loads++;
    #1;
    chk("b2b resp_valid", 32'(resp_valid), 32'd1);
    chk("b2b resp_rdata", resp_rdata, 32'h0000_AB01);
    @(negedge clk);
    #1;
    chk("pulse resp_valid", 32'(resp_valid), 32'd0);
    chk("hold resp_rdata", resp_rdata, 32'h0000_AB01);
    chk("idle mem_write_data", mem_write_data, 32'd0);

    // Reset raised during RMW_WR suppresses the write.
    drive(1'b1, 2'b01, 1'b0, 32'h0000_0014, 32'h0000_5555);
    #1;
    chk("rst-rmw mem_read", 32'(mem_read), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst-rmw mem_write", 32'(mem_write), 32'd0);
    chk("rst-rmw mem_address", mem_address, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    n_loads = 0; n_stores = 0; n_stalls = 0;
    #1;
    chk("rst-rmw req_ready", 32'(req_ready), 32'd1);
    chk("rst-rmw mem_write idle", 32'(mem_write), 32'd0);
    chk("rst-rmw mem_word5", mem[5], 32'h1122_3344);
    drive(1'b0, 2'b10, 1'b0, 32'h0000_0014, 32'h0);
    @(negedge clk);
    req_valid = 1'b0;
    n_loads++;
    #1;
    chk("rst-rmw load rdata", resp_rdata, 32'h1122_3344);

    // Upper-half store ignores wdata bits above the lane.
    @(negedge clk);
    drive(1'b1, 2'b01, 1'b0, 32'h0000_0016, 32'hFFFF_BEEF);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    chk("hi-half mem_write_data", mem_write_data, 32'hBEEF_3344);
    chk("hi-half mem_address", mem_address, 32'd5);
    n_stores++; n_stalls++;
    @(negedge clk);
    drive(1'b0, 2'b01, 1'b1, 32'h0000_0016, 32'h0);
    @(negedge clk);
    req_valid = 1'b0;
    n_loads++;
    #1;
    chk("hi-half load rdata", resp_rdata, 32'hFFFF_BEEF);
    chk("hi-half mem_word5", mem[5], 32'hBEEF_3344);

`ifdef MEM_ACCESS_PERF_EN
    chk("perf_loads", perf_loads, 32'(n_loads));
    chk("perf_stores", perf_stores, 32'(n_stores));
    chk("perf_stall_cycles", perf_stall_cycles, 32'(n_stalls));
`endif

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage initiator for the word-organised data memory.
- Accepts byte-addressed load/store requests from the EX/MEM register and drives memRead/memWrite/address/writeData toward DataMemory.
- Adds byte/halfword loads (sign or zero extended), and byte/halfword stores via a 2-cycle read-modify-write; stalls the pipeline during the RMW write cycle.
- Registers results toward MEM/WB.

Parameters:
- WORD_IDX_W, 10, word-index bits driven on mem_address (memory depth 2^WORD_IDX_W words).

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present this cycle.
- req_ready  out  1  request accepted this cycle; low = stall.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = half, 10 = word; 11 = reserved, treated as word.
- req_signed  in  1  sign-extend sub-word loads.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  load result/error valid; one-cycle pulse.
- resp_rdata  out  32  extended load data.
- resp_err  out  1  misaligned access flag.
- mem_read  out  1  to memRead.
- mem_write  out  1  to memWrite.
- mem_address  out  32  word index: req_addr[WORD_IDX_W+1:2], zero-extended.
- mem_write_data  out  32  to writeData.
- mem_read_data  in  32  from readData; combinational same cycle.

Behaviour:
- Little-endian lanes.
  - Byte lane = addr[1:0].
  - Half lane = addr[1]; low half = bits 15:0.
- Misaligned accesses:
  - Half with addr[0]=1, or word with addr[1:0]!=0, is misaligned.
  - No memory strobe is issued.
  - Next cycle: resp_valid=1, resp_err=1, resp_rdata=0; stores included.
- State machine: states IDLE and RMW_WR.
- IDLE:
  - req_ready=1.
  - mem_read, mem_write and mem_address are combinational from the request.
  - Load:
    - mem_read=1.
    - Lane is extracted from mem_read_data and extended (sign if req_signed, else zero).
    - Registered to resp_rdata with resp_valid=1 next cycle. Latency 1.
  - Word store:
    - mem_write=1, mem_write_data=req_wdata.
    - Write lands at this edge; stays IDLE; no resp_valid.
  - Sub-word store:
    - mem_read=1, mem_write=0.
    - Merged word is latched: old word with the target lane replaced by req_wdata[7:0] or [15:0].
    - Word index is latched.
    - Go to RMW_WR.
- RMW_WR:
  - req_ready=0, mem_write=1, mem_read=0.
  - Latched index and merged data are driven.
  - Return to IDLE next edge; total store occupancy 2 cycles.
- No request (IDLE, req_valid=0): all strobes are 0.
- Output registers:
  - resp_valid is low every cycle not following a load or error.
  - resp_rdata holds its last value.
  - mem_address and mem_write_data are 0 whenever both strobes are 0.
- Reset:
  - Outputs clear at the next edge: resp_valid=0, resp_rdata=0, resp_err=0, state=IDLE, latches=0.
  - Reset asserted during RMW_WR suppresses that write: mem_write is gated by !reset.
  - All strobes are forced to 0 while reset=1.
- Back-to-back traffic: a load issued the cycle after RMW_WR sees the updated word; no bypass is needed.

Optional Feature:
- Macro: MEM_ACCESS_PERF_EN.
- Defined: adds outputs perf_loads, perf_stores and perf_stall_cycles, each 32 bit.
  - Counters increment on accepted loads, accepted stores and RMW_WR cycles respectively.
  - Counters wrap at 2^32 and clear on reset.
  - Error accesses are not counted.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package mem_access_pkg:
  - size encodings SZ_BYTE / SZ_HALF / SZ_WORD.
  - state enum IDLE / RMW_WR.
  - lane-merge and load-extend functions.
- One natural sub-module: mem_lane_align, combinational.
  - Performs load extract/extend and store merge.
  - Shared by the load path and the RMW path; tested standalone.

Test Plan:
- Preload word 2 = 0x00000003; word load at byte addr 0x08 -> mem_read=1, mem_address=2; next cycle resp_valid=1, resp_rdata=0x00000003.
- Preload word 4 = 0x00008005; signed byte load at 0x10 -> 0x00000005. Signed half load at 0x10 -> 0xFFFF8005. Unsigned half load at 0x10 -> 0x00008005.
- Preload word 3 = 0x00000001; byte store 0xAB at 0x0D -> req_ready=0 for exactly 1 cycle, mem_write_data=0x0000AB01 at index 3; then a load at 0x0C returns 0x0000AB01.
- Word load at 0x06 -> no strobes; next cycle resp_err=1, resp_rdata=0. Half store at 0x0B -> no write, resp_err=1.
- Half store at 0x14, reset raised in RMW_WR -> mem_write stays 0, word 5 unchanged, state returns to IDLE.
- With MEM_ACCESS_PERF_EN: 3 loads plus 2 byte stores -> perf_loads=3, perf_stores=2, perf_stall_cycles=2.
